// File: rtl/enemy_array_hit.sv
// enemy_array_hit
//
// Projectile-versus-enemy collision and round bookkeeping for an array of
// enemy slots.
//
// A projectile sample is captured on one rising edge. The hit decision, the
// alive update, hit_pulse and proj_consume all appear on the following edge.
// Only slots that were alive when the projectile was sampled, and are still
// alive at the response edge, can be hit. At most the lowest-index such slot
// is killed per sample.
//
// Configuration macro: ENEMY_SCORE_EN
//   defined   -> saturating hit counter drives score
//   undefined -> no counter register, score is tied to 0
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset (enters IDLE)
//   start        single-cycle round start / restart pulse
//   enemy_h      enemy centre X, slot i at [i*COORD_W +: COORD_W]
//   enemy_v      enemy centre Y, same packing
//   enemy_spawn  per-slot revive pulse (honoured in ACTIVE only)
//   proj_valid   projectile coordinates valid this cycle
//   proj_h       projectile centre X
//   proj_v       projectile centre Y
//   alive        registered per-slot alive flags
//   hit_pulse    one-hot, one-cycle pulse marking the slot that was hit
//   proj_consume one-cycle pulse: projectile struck an enemy, retire it
//   all_dead     high while the round is CLEARED
//   score        saturating hit count (0 when the counter is not built)

module enemy_array_hit #(
  parameter int N_ENEMY    = 4,
  parameter int COORD_W    = 10,
  parameter int HIT_RADIUS = 25,
  parameter int SCORE_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N_ENEMY*COORD_W-1:0]   enemy_h,
  input  logic [N_ENEMY*COORD_W-1:0]   enemy_v,
  input  logic [N_ENEMY-1:0]           enemy_spawn,
  input  logic                         proj_valid,
  input  logic [COORD_W-1:0]           proj_h,
  input  logic [COORD_W-1:0]           proj_v,
  output logic [N_ENEMY-1:0]           alive,
  output logic [N_ENEMY-1:0]           hit_pulse,
  output logic                         proj_consume,
  output logic                         all_dead,
  output logic [SCORE_W-1:0]           score
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CLEARED = 2'd2
  } state_t;

  localparam logic [COORD_W:0] RADIUS = (COORD_W+1)'(HIT_RADIUS);

  state_t               state;
  state_t               state_next;
  logic [N_ENEMY-1:0]   alive_next;
  logic [N_ENEMY-1:0]   in_box;
  logic                 pend_valid;
  logic [N_ENEMY-1:0]   pend_cand;
  logic [N_ENEMY-1:0]   cand;
  logic [N_ENEMY-1:0]   sel;
  logic                 found;
  logic [N_ENEMY-1:0]   kill;
  logic                 score_clear;

  // Distance test on one axis. Both operands are zero-extended into a
  // COORD_W+1-bit signed difference, so a projectile at 0 and an enemy near
  // the top of the range never alias through unsigned wrap.
  function automatic logic near(input logic [COORD_W-1:0] a,
                                input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    logic [COORD_W:0]        mag;
    d   = $signed({1'b0, a}) - $signed({1'b0, b});
    mag = d[COORD_W] ? $unsigned(-d) : $unsigned(d);
    return mag <= RADIUS;
  endfunction

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_box
    assign in_box[g] = near(proj_h, enemy_h[g*COORD_W +: COORD_W]) &&
                       near(proj_v, enemy_v[g*COORD_W +: COORD_W]);
  end

  // Candidate set is frozen against the alive flags at sample time, then
  // re-masked with the current flags so a slot killed or dead in between
  // cannot be hit.
  assign cand = pend_cand & alive & {N_ENEMY{pend_valid}};

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (cand[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // A revive on the selected slot cancels the whole hit; start also cancels.
  assign kill = (state == ACTIVE && !start) ? (sel & ~enemy_spawn) : '0;

  always_comb begin
    state_next = state;
    alive_next = alive;
    case (state)
      IDLE: begin
        alive_next = '0;
        if (start) begin
          state_next = ACTIVE;
          alive_next = '1;
        end
      end
      ACTIVE: begin
        if (start) begin
          alive_next = '1;
        end else begin
          alive_next = (alive & ~kill) | enemy_spawn;
          if (alive_next == '0) state_next = CLEARED;
        end
      end
      CLEARED: begin
        alive_next = '0;
        if (start) begin
          state_next = ACTIVE;
          alive_next = '1;
        end
      end
      default: begin
        state_next = IDLE;
        alive_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      alive        <= '0;
      hit_pulse    <= '0;
      proj_consume <= 1'b0;
      pend_valid   <= 1'b0;
      pend_cand    <= '0;
    end else begin
      state        <= state_next;
      alive        <= alive_next;
      hit_pulse    <= kill;
      proj_consume <= |kill;
      pend_valid   <= proj_valid && (state == ACTIVE) && !start;
      pend_cand    <= in_box & alive;
    end
  end

  assign all_dead    = (state == CLEARED);
  assign score_clear = (state == IDLE) && start;

`ifdef ENEMY_SCORE_EN
  logic [SCORE_W-1:0] score_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (score_clear) begin
      score_q <= '0;
    end else if ((|kill) && (score_q != '1)) begin
      score_q <= score_q + SCORE_W'(1);
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_enemy_array_hit.sv
// Testbench for enemy_array_hit: directed scenarios plus a randomized run,
// all checked against a behavioural round model kept in this file.
// Honours ENEMY_SCORE_EN the same way as the design build.

module tb_enemy_array_hit;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int R  = 25;
  localparam int SW = 8;
  localparam int SCORE_MAX = (1 << SW) - 1;

`ifdef ENEMY_SCORE_EN
  localparam int SCORE_ON = 1;
`else
  localparam int SCORE_ON = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [N*CW-1:0] enemy_h;
  logic [N*CW-1:0] enemy_v;
  logic [N-1:0]    enemy_spawn;
  logic            proj_valid;
  logic [CW-1:0]   proj_h;
  logic [CW-1:0]   proj_v;
  logic [N-1:0]    alive;
  logic [N-1:0]    hit_pulse;
  logic            proj_consume;
  logic            all_dead;
  logic [SW-1:0]   score;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: round phase, alive set, pending projectile target set.
  int           m_phase;        // 0 waiting, 1 playing, 2 cleared
  logic [N-1:0] exp_alive;
  logic [N-1:0] exp_hit;
  logic         exp_consume;
  int           exp_score;
  bit           pend_valid;
  logic [N-1:0] pend_targets;

  enemy_array_hit #(
    .N_ENEMY(N), .COORD_W(CW), .HIT_RADIUS(R), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .enemy_h(enemy_h), .enemy_v(enemy_v), .enemy_spawn(enemy_spawn),
    .proj_valid(proj_valid), .proj_h(proj_h), .proj_v(proj_v),
    .alive(alive), .hit_pulse(hit_pulse), .proj_consume(proj_consume),
    .all_dead(all_dead), .score(score)
  );

  always #5 clk = ~clk;

  function automatic bit near(input int a, input int b);
    return ((a > b) ? (a - b) : (b - a)) <= R;
  endfunction

  task automatic model_reset();
    m_phase      = 0;
    exp_alive    = '0;
    exp_hit      = '0;
    exp_consume  = 1'b0;
    exp_score    = 0;
    pend_valid   = 1'b0;
    pend_targets = '0;
  endtask

  // One clock edge of the round rules, using the inputs present at the edge.
  task automatic model_step();
    logic [N-1:0] targets_now;
    logic [N-1:0] new_alive;
    int victim;
    for (int i = 0; i < N; i++)
      targets_now[i] = exp_alive[i] &&
                       near(int'(proj_h), int'(enemy_h[i*CW +: CW])) &&
                       near(int'(proj_v), int'(enemy_v[i*CW +: CW]));
    exp_hit     = '0;
    exp_consume = 1'b0;
    if (m_phase == 1) begin
      if (start) begin
        exp_alive  = '1;
        pend_valid = 1'b0;
      end else begin
        victim = -1;
        if (pend_valid)
          for (int i = 0; i < N; i++)
            if (victim < 0 && pend_targets[i] && exp_alive[i]) victim = i;
        new_alive = exp_alive | enemy_spawn;
        if (victim >= 0 && !enemy_spawn[victim]) begin
          new_alive[victim] = 1'b0;
          exp_hit[victim]   = 1'b1;
          exp_consume       = 1'b1;
`ifdef ENEMY_SCORE_EN
          if (exp_score < SCORE_MAX) exp_score = exp_score + 1;
`endif
        end
        exp_alive = new_alive;
        if (new_alive == '0) m_phase = 2;
        pend_valid   = proj_valid;
        pend_targets = targets_now;
      end
    end else begin
      pend_valid = 1'b0;
      if (start) begin
        if (m_phase == 0) exp_score = 0;
        m_phase   = 1;
        exp_alive = '1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start       = 1'b0;
    enemy_spawn = '0;
    proj_valid  = 1'b0;
  endtask

  task automatic place(input int i, input int h, input int v);
    enemy_h[i*CW +: CW] = CW'(h);
    enemy_v[i*CW +: CW] = CW'(v);
  endtask

  task automatic place_all(input int h, input int v);
    for (int i = 0; i < N; i++) place(i, h, v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic begin_round();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sample a projectile on one edge, leave outputs of the response edge visible.
  task automatic shoot(input int h, input int v);
    proj_h     = CW'(h);
    proj_v     = CW'(v);
    proj_valid = 1'b1;
    tick();
    proj_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    place_all(0, 0);
    proj_h = '0;
    proj_v = '0;
    model_reset();
    #2;
    checks++;
    if (alive !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_alive got=%b want=0000", alive);
    end
    checks++;
    if (hit_pulse !== 4'b0000 || proj_consume !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pulses got=%b/%b want=0000/0", hit_pulse, proj_consume);
    end
    checks++;
    if (all_dead !== 1'b0 || score !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_status got=%b/%0d want=0/0", all_dead, score);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (alive !== 4'b0000 || all_dead !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_after_reset got=%b/%b want=0000/0", alive, all_dead);
    end
  endtask

  task automatic test_basic_hit();
    do_reset();
    begin_round();
    checks++;
    if (alive !== 4'b1111) begin
      failures++; $display("[TB] FAIL start_alive got=%b want=1111", alive);
    end
    place_all(100, 100);
    shoot(125, 75);
    checks++;
    if (hit_pulse !== 4'b0001) begin
      failures++; $display("[TB] FAIL basic_hit got=%b want=0001", hit_pulse);
    end
    checks++;
    if (alive !== 4'b1110 || proj_consume !== 1'b1) begin
      failures++; $display("[TB] FAIL basic_alive_consume got=%b/%b want=1110/1", alive, proj_consume);
    end
    checks++;
    if (score !== SW'(SCORE_ON)) begin
      failures++; $display("[TB] FAIL basic_score got=%0d want=%0d", score, SCORE_ON);
    end
    tick();
    checks++;
    if (hit_pulse !== 4'b0000 || proj_consume !== 1'b0) begin
      failures++; $display("[TB] FAIL pulse_one_cycle got=%b/%b want=0000/0", hit_pulse, proj_consume);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    begin_round();
    place_all(700, 700);
    place(0, 100, 100);
    shoot(126, 100);
    checks++;
    if (hit_pulse !== 4'b0000 || alive !== 4'b1111) begin
      failures++; $display("[TB] FAIL radius_plus_one got=%b/%b want=0000/1111", hit_pulse, alive);
    end
    shoot(100, 125);
    checks++;
    if (hit_pulse !== 4'b0001) begin
      failures++; $display("[TB] FAIL radius_exact got=%b want=0001", hit_pulse);
    end
    place(0, 10, 10);
    begin_round();
    shoot(0, 0);
    checks++;
    if (hit_pulse !== 4'b0001) begin
      failures++; $display("[TB] FAIL low_edge got=%b want=0001", hit_pulse);
    end
    begin_round();
    shoot(1000, 10);
    checks++;
    if (hit_pulse !== 4'b0000 || proj_consume !== 1'b0) begin
      failures++; $display("[TB] FAIL no_wrap got=%b/%b want=0000/0", hit_pulse, proj_consume);
    end
  endtask

  task automatic test_back_to_back_clear();
    logic [N-1:0] want;
    do_reset();
    begin_round();
    place_all(100, 100);
    proj_h = CW'(100);
    proj_v = CW'(100);
    proj_valid = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) proj_valid = 1'b0;
      tick();
      want = N'(1 << k);
      checks++;
      if (hit_pulse !== want || all_dead !== (k == N - 1)) begin
        failures++; $display("[TB] FAIL kill_seq_%0d got=%b/%b want=%b/%b", k, hit_pulse, all_dead, want, (k == N - 1));
      end
    end
    proj_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (hit_pulse !== 4'b0000 || all_dead !== 1'b1 || alive !== 4'b0000) begin
        failures++; $display("[TB] FAIL cleared_ignores got=%b/%b/%b want=0000/1/0000", hit_pulse, all_dead, alive);
      end
    end
    proj_valid = 1'b0;
    begin_round();
    checks++;
    if (alive !== 4'b1111 || all_dead !== 1'b0 || score !== SW'(4 * SCORE_ON)) begin
      failures++; $display("[TB] FAIL restart_retains got=%b/%b/%0d want=1111/0/%0d", alive, all_dead, score, 4 * SCORE_ON);
    end
  endtask

  task automatic test_spawn();
    do_reset();
    begin_round();
    place_all(800, 800);
    place(2, 300, 300);
    shoot(300, 300);
    checks++;
    if (hit_pulse !== 4'b0100 || alive !== 4'b1011) begin
      failures++; $display("[TB] FAIL kill_slot2 got=%b/%b want=0100/1011", hit_pulse, alive);
    end
    enemy_spawn = 4'b0100;
    proj_valid  = 1'b1;
    tick();
    enemy_spawn = '0;
    proj_valid  = 1'b0;
    checks++;
    if (alive !== 4'b1111) begin
      failures++; $display("[TB] FAIL spawn_revives got=%b want=1111", alive);
    end
    tick();
    checks++;
    if (hit_pulse !== 4'b0000 || proj_consume !== 1'b0 || score !== SW'(SCORE_ON)) begin
      failures++; $display("[TB] FAIL spawn_dead_no_hit got=%b/%b/%0d want=0000/0/%0d", hit_pulse, proj_consume, score, SCORE_ON);
    end
    proj_valid = 1'b1;
    tick();
    proj_valid  = 1'b0;
    enemy_spawn = 4'b0100;
    tick();
    enemy_spawn = '0;
    checks++;
    if (hit_pulse !== 4'b0000 || proj_consume !== 1'b0 || alive !== 4'b1111) begin
      failures++; $display("[TB] FAIL spawn_wins got=%b/%b/%b want=0000/0/1111", hit_pulse, proj_consume, alive);
    end
    place_all(300, 300);
    proj_valid = 1'b1;
    start      = 1'b1;
    tick();
    proj_valid = 1'b0;
    start      = 1'b0;
    tick();
    checks++;
    if (hit_pulse !== 4'b0000 || alive !== 4'b1111) begin
      failures++; $display("[TB] FAIL start_suppresses got=%b/%b want=0000/1111", hit_pulse, alive);
    end
  endtask

  task automatic test_reset_mid_round();
    do_reset();
    begin_round();
    place_all(100, 100);
    proj_h = CW'(100);
    proj_v = CW'(100);
    proj_valid = 1'b1;
    tick();
    proj_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({alive, hit_pulse, proj_consume, all_dead, score} !== '0) begin
      failures++; $display("[TB] FAIL async_reset got=%b/%b/%b/%b/%0d want=all 0", alive, hit_pulse, proj_consume, all_dead, score);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({alive, hit_pulse, proj_consume, all_dead, score} !== '0) begin
        failures++; $display("[TB] FAIL reset_discards_%0d got=%b/%b/%b/%b/%0d want=all 0", k, alive, hit_pulse, proj_consume, all_dead, score);
      end
    end
  endtask

  task automatic test_score_saturation();
    do_reset();
    begin_round();
    place_all(100, 100);
    proj_h = CW'(100);
    proj_v = CW'(100);
    for (int r = 0; r < 65; r++) begin
      for (int k = 0; k < N + 2; k++) begin
        proj_valid = (k < N);
        start      = (k == N + 1);
        tick();
        checks++;
        if (score !== SW'(exp_score)) begin
          failures++; $display("[TB] FAIL score_round_%0d got=%0d want=%0d", r, score, exp_score);
        end
      end
    end
    idle_inputs();
    checks++;
    if (score !== SW'(SCORE_ON * SCORE_MAX)) begin
      failures++; $display("[TB] FAIL score_saturated got=%0d want=%0d", score, SCORE_ON * SCORE_MAX);
    end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    begin_round();
    for (int n = 0; n < 3000; n++) begin
      base = ($urandom_range(0, 1) == 0) ? 0 : 940;
      for (int i = 0; i < N; i++)
        place(i, base + $urandom_range(0, 83), base + $urandom_range(0, 83));
      proj_h      = CW'(base + $urandom_range(0, 83));
      proj_v      = CW'(base + $urandom_range(0, 83));
      proj_valid  = ($urandom_range(0, 1) == 1);
      enemy_spawn = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      start       = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      tick();
      reset = 1'b0;
      checks++;
      if (alive !== exp_alive) begin
        failures++; $display("[TB] FAIL rand_alive n=%0d got=%b want=%b", n, alive, exp_alive);
      end
      checks++;
      if (hit_pulse !== exp_hit || proj_consume !== exp_consume) begin
        failures++; $display("[TB] FAIL rand_hit n=%0d got=%b/%b want=%b/%b", n, hit_pulse, proj_consume, exp_hit, exp_consume);
      end
      checks++;
      if (all_dead !== (m_phase == 2) || score !== SW'(exp_score)) begin
        failures++; $display("[TB] FAIL rand_status n=%0d got=%b/%0d want=%b/%0d", n, all_dead, score, (m_phase == 2), exp_score);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_boundary();
    test_back_to_back_clear();
    test_spawn();
    test_reset_mid_round();
    test_score_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_array_hit.md
ENEMY_ARRAY_HIT -- requirements
Module: enemy_array_hit

Interface
REQ-001 Parameter N_ENEMY, default 4, number of enemy slots (1..16).
REQ-002 Parameter COORD_W, default 10, width of each pixel coordinate.
REQ-003 Parameter HIT_RADIUS, default 25, half-width of the square hitbox in pixels.
REQ-004 Parameter SCORE_W, default 8, width of the score counter.
REQ-005 Port clk  input  1  system clock; all logic on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  single-cycle round start/restart pulse.
REQ-008 Port enemy_h  input  N_ENEMY*COORD_W  enemy centre X, slot i at bits [i*COORD_W +: COORD_W].
REQ-009 Port enemy_v  input  N_ENEMY*COORD_W  enemy centre Y, same packing.
REQ-010 Port enemy_spawn  input  N_ENEMY  per-slot revive pulse.
REQ-011 Port proj_valid  input  1  projectile coordinates valid this cycle.
REQ-012 Port proj_h, proj_v  input  COORD_W each  projectile centre.
REQ-013 Port alive  output  N_ENEMY  registered per-slot alive flags.
REQ-014 Port hit_pulse  output  N_ENEMY  one-hot, one-cycle pulse marking the slot hit.
REQ-015 Port proj_consume  output  1  one-cycle pulse: projectile struck an enemy, projectile owner shall retire it.
REQ-016 Port all_dead  output  1  high while in CLEARED state.
REQ-017 Port score  output  SCORE_W  saturating hit count.

Function
REQ-018 FSM states IDLE, ACTIVE, CLEARED; reset enters IDLE.
REQ-019 IDLE: alive all 0; start -> ACTIVE with alive all 1 on the next edge; score cleared on that edge.
REQ-020 ACTIVE: proj_valid sampled at edge t; hit_pulse, proj_consume and the alive clear appear at edge t+1 (latency 1).
REQ-021 Hit test per slot: alive, |proj_h-enemy_h| <= HIT_RADIUS and |proj_v-enemy_v| <= HIT_RADIUS, computed with COORD_W+1-bit signed differences; no unsigned wrap at coordinate 0 or max.
REQ-022 Distance exactly HIT_RADIUS is a hit; HIT_RADIUS+1 is a miss.
REQ-023 Multiple candidate slots: only the lowest-index alive slot is hit; one kill per projectile sample.
REQ-024 enemy_spawn[i] in ACTIVE sets alive[i] next edge; spawn and hit on the same slot in the same cycle: spawn wins, no hit_pulse, no consume, no score.
REQ-025 Dead slots never hit; proj_valid low produces no outputs.
REQ-026 ACTIVE -> CLEARED on the edge where the last alive bit clears; all_dead high from that edge.
REQ-027 CLEARED: enemy_spawn and proj_valid ignored; start -> ACTIVE with alive all 1, score retained.
REQ-028 start in ACTIVE: alive all 1 next edge, any hit sampled that cycle suppressed, score retained.
REQ-029 Score increments by 1 per hit_pulse, saturates at all-ones, never wraps.

Reset
REQ-030 Reset asynchronous assert, state IDLE, alive 0, hit_pulse 0, proj_consume 0, all_dead 0, score 0.
REQ-031 Reset mid-round discards any pending hit; no pulse emitted after release until a new start.

Configuration
REQ-032 Macro ENEMY_SCORE_EN defined: score counter built per REQ-029.
REQ-033 Macro ENEMY_SCORE_EN undefined: no counter register; score port driven constant 0; all other behaviour identical.

Verification
REQ-034 Reset, start, N_ENEMY=4, all slots at (100,100), proj (125,75) valid -> next cycle hit_pulse=0001, alive=1110, proj_consume=1, score=1.
REQ-035 Slot0 at (100,100), proj (126,100) -> no hit; proj (100,125) -> hit; enemy at (10,10), proj (0,0) -> hit, (1000,10) -> miss (no wrap).
REQ-036 Kill slots 0..3 sequentially -> all_dead rises with the fourth hit; further proj_valid -> no pulses; start -> alive=1111, score=4 retained.
REQ-037 Slot2 dead, enemy_spawn=0100 with in-box projectile for slot2 only -> alive[2]=1, hit_pulse=0, score unchanged.
REQ-038 Score at 255 (SCORE_W=8) plus one hit -> score stays 255; build without ENEMY_SCORE_EN -> score always 0.
REQ-039 Assert reset for one cycle between a valid in-box projectile sample and its response edge -> no hit_pulse, state IDLE, all outputs 0.
